seq_alu: RTL

- Parametrised, multi-cycle successor to the combinational CPU ALU.
- Same opcode map (ADD..NOT), generalised to WIDTH bits.
- Adds a start/done handshake, status flags, and iterative shift-add MUL and restoring DIV in place of single-cycle array logic.
- Sits between ControlUnit/RegisterFile operands and the writeback path of TopLevelCPU; the core stalls on busy.

---
 rtl/seq_alu_if.sv | 27 ++
 rtl/seq_alu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// Operand/result bus between the CPU core and seq_alu: start/done handshake, operands, status.
// The core side drives the master modport; the ALU takes the slave modport.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 19
);
    logic             start;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             div_by_zero;
    logic             illegal_op;

    modport master (
        output start, opcode, a, b,
        input  busy, done, result, zero, carry, div_by_zero, illegal_op
    );

    modport slave (
        input  start, opcode, a, b,
        output busy, done, result, zero, carry, div_by_zero, illegal_op
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/add ops, iterative shift-add MUL and restoring DIV.
// Optional SEQ_ALU_SHIFT_EN adds single-cycle SHL (1010) and SHR (1011).
module seq_alu #(
    parameter int unsigned WIDTH = 19
) (
    input logic      clk,
    input logic      reset,
    seq_alu_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    localparam logic [3:0] OpAdd = 4'b0000;
    localparam logic [3:0] OpSub = 4'b0001;
    localparam logic [3:0] OpMul = 4'b0010;
    localparam logic [3:0] OpDiv = 4'b0011;
    localparam logic [3:0] OpInc = 4'b0100;
    localparam logic [3:0] OpDec = 4'b0101;
    localparam logic [3:0] OpAnd = 4'b0110;
    localparam logic [3:0] OpOr  = 4'b0111;
    localparam logic [3:0] OpXor = 4'b1000;
    localparam logic [3:0] OpNot = 4'b1001;
`ifdef SEQ_ALU_SHIFT_EN
    localparam logic [3:0] OpShl = 4'b1010;
    localparam logic [3:0] OpShr = 4'b1011;
`endif

    typedef enum logic [0:0] {StIdle, StIter} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;      // MUL multiplicand / DIV dividend-then-quotient
    logic [WIDTH-1:0] y_q, y_d;      // MUL multiplier / DIV divisor
    logic [WIDTH:0]   acc_q, acc_d;  // MUL product / DIV partial remainder
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             dbz_q, dbz_d;
    logic             ill_q, ill_d;

    logic             accept;
    logic [WIDTH-1:0] op_res;
    logic             op_carry, op_dbz, op_ill, op_iter;
    logic [WIDTH:0]   mul_sum, rem_sh, trial;
    logic [WIDTH-1:0] fin;
`ifdef SEQ_ALU_SHIFT_EN
    logic [WIDTH-1:0] sh_pre;
`endif

    assign accept = bus.start && (state_q == StIdle);

    always_comb begin
        op_res   = '0;
        op_carry = 1'b0;
        op_dbz   = 1'b0;
        op_ill   = 1'b0;
        op_iter  = 1'b0;
`ifdef SEQ_ALU_SHIFT_EN
        sh_pre   = '0;
`endif
        case (bus.opcode)
            OpAdd: {op_carry, op_res} = {1'b0, bus.a} + {1'b0, bus.b};
            OpSub: {op_carry, op_res} = {1'b0, bus.a} - {1'b0, bus.b};
            OpMul: op_iter = 1'b1;
            OpDiv: begin
                if (bus.b == '0) begin
                    op_res = '1;
                    op_dbz = 1'b1;
                end else begin
                    op_iter = 1'b1;
                end
            end
            OpInc: {op_carry, op_res} = {1'b0, bus.a} + (WIDTH + 1)'(1);
            OpDec: {op_carry, op_res} = {1'b0, bus.a} - (WIDTH + 1)'(1);
            OpAnd: op_res = bus.a & bus.b;
            OpOr:  op_res = bus.a | bus.b;
            OpXor: op_res = bus.a ^ bus.b;
            OpNot: op_res = ~bus.a;
`ifdef SEQ_ALU_SHIFT_EN
            // Shifting by b-1 leaves the last bit shifted out at the edge of the word.
            OpShl: begin
                op_res = bus.a << bus.b;
                if (bus.b != '0) begin
                    sh_pre   = bus.a << (bus.b - WIDTH'(1));
                    op_carry = sh_pre[WIDTH-1];
                end
            end
            OpShr: begin
                op_res = bus.a >> bus.b;
                if (bus.b != '0) begin
                    sh_pre   = bus.a >> (bus.b - WIDTH'(1));
                    op_carry = sh_pre[0];
                end
            end
`endif
            default: op_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        result_d = result_q;
        done_d   = 1'b0;
        zero_d   = zero_q;
        carry_d  = carry_q;
        dbz_d    = dbz_q;
        ill_d    = ill_q;
        fin      = '0;
        mul_sum  = acc_q + {1'b0, x_q};
        rem_sh   = {acc_q[WIDTH-1:0], x_q[WIDTH-1]};
        trial    = rem_sh - {1'b0, y_q};

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (op_iter) begin
                        state_d  = StIter;
                        x_d      = bus.a;
                        y_d      = bus.b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        is_div_d = (bus.opcode == OpDiv);
                    end else begin
                        done_d   = 1'b1;
                        result_d = op_res;
                        zero_d   = (op_res == '0);
                        carry_d  = op_carry;
                        dbz_d    = op_dbz;
                        ill_d    = op_ill;
                    end
                end
            end
            StIter: begin
                cnt_d = cnt_q + CntW'(1);
                if (is_div_q) begin
                    // Borrow in the top bit means the trial subtraction failed: restore.
                    x_d   = {x_q[WIDTH-2:0], ~trial[WIDTH]};
                    acc_d = trial[WIDTH] ? rem_sh : trial;
                end else begin
                    if (y_q[0]) begin
                        acc_d = mul_sum;
                    end
                    x_d = x_q << 1;
                    y_d = y_q >> 1;
                end
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    fin      = is_div_q ? x_d : acc_d[WIDTH-1:0];
                    state_d  = StIdle;
                    done_d   = 1'b1;
                    result_d = fin;
                    zero_d   = (fin == '0);
                    carry_d  = 1'b0;
                    dbz_d    = 1'b0;
                    ill_d    = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            dbz_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            result_q <= result_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            dbz_q    <= dbz_d;
            ill_q    <= ill_d;
        end
    end

    assign bus.busy        = (state_q == StIter);
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.zero        = zero_q;
    assign bus.carry       = carry_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.illegal_op  = ill_q;
endmodule
